// File: rtl/mp_scalar_mul_18.sv
// ---------------------------------------------------------------------------
// mp_scalar_mul_18
//   Limb-serial multi-precision scalar multiplier. Streams an N-limb operand A
//   (18-bit limbs, least significant first) and returns R = A*b + c_init as
//   N+1 result limbs. The upper half of each limb product is fed back as the
//   addend for the next limb; the final carry becomes the last result limb.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle request, only honoured in IDLE
//   b_scalar, c_init  scalar and initial addend, latched on an accepted start
//   busy              high whenever an operation is in progress
//   a_valid/a_ready   operand limb handshake; a_limb data, a_last marks MS limb
//   r_valid/r_ready   result limb handshake; r_limb data, r_index position,
//                     r_last marks the final carry limb
// ---------------------------------------------------------------------------

// 18x18 multiply plus 18-bit addend. Max value is 2^36 - 2^18, so the
// 36-bit sum never overflows and splits cleanly into two 18-bit halves.
module mp_scalar_mul_18_mac (
   input  logic [17:0] a,
   input  logic [17:0] b,
   input  logic [17:0] c,
   output logic [17:0] lo,
   output logic [17:0] hi
);
   logic [35:0] p;

   always_comb begin
      p  = 36'(a) * 36'(b) + 36'(c);
      lo = p[17:0];
      hi = p[35:18];
   end
endmodule

module mp_scalar_mul_18 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [17:0]      b_scalar,
   input  logic [17:0]      c_init,
   output logic             busy,
   input  logic             a_valid,
   input  logic [17:0]      a_limb,
   input  logic             a_last,
   output logic             a_ready,
   output logic             r_valid,
   output logic [17:0]      r_limb,
   output logic [CNT_W-1:0] r_index,
   output logic             r_last,
   input  logic             r_ready
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      TAIL  = 3'd3,
      FIN   = 3'd4
   } state_t;

   // Output register contents, kept together so they update as one unit.
   typedef struct packed {
      logic             valid;
      logic             last;
      logic [CNT_W-1:0] index;
      logic [17:0]      limb;
   } rslt_t;

   state_t           state, state_nxt;
   rslt_t            rslt;
   logic             s1_valid;
   logic [17:0]      s1_limb;
   logic [17:0]      b_q;
   logic [17:0]      carry_q;
   logic [CNT_W-1:0] idx;
   logic             adv;
   logic [17:0]      mac_lo, mac_hi;

   // The whole pipeline moves when the output register is empty or being
   // drained this cycle; otherwise every stage holds.
   assign adv     = !rslt.valid || r_ready;
   assign a_ready = (state == RUN) && adv;
   assign busy    = (state != IDLE);

   assign r_valid = rslt.valid;
   assign r_last  = rslt.last;
   assign r_index = rslt.index;
   assign r_limb  = rslt.limb;

   mp_scalar_mul_18_mac u_mac (
      .a  (s1_limb),
      .b  (b_q),
      .c  (carry_q),
      .lo (mac_lo),
      .hi (mac_hi)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = RUN;
         RUN:   if (a_valid && a_ready && a_last) state_nxt = DRAIN;
         // Stage 1 is empty, or it empties into the output register on this
         // edge; either way carry_q is final after the edge.
         DRAIN: if (!s1_valid || adv) state_nxt = TAIL;
         TAIL:  if (adv) state_nxt = FIN;
         FIN:   if (rslt.valid && r_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_limb  <= '0;
         b_q      <= '0;
         carry_q  <= '0;
         idx      <= '0;
         rslt     <= '0;
      end else begin
         if (state == IDLE && start) begin
            b_q     <= b_scalar;
            carry_q <= c_init;
            idx     <= '0;
         end
         if (adv) begin
            s1_valid <= a_valid && a_ready;
            s1_limb  <= a_limb;
            if (s1_valid) begin
               rslt.valid <= 1'b1;
               rslt.last  <= 1'b0;
               rslt.index <= idx;
               rslt.limb  <= mac_lo;
               carry_q    <= mac_hi;
               idx        <= idx + 1'b1;
            end else if (state == TAIL) begin
               // Final limb is the carry left over from the top operand limb.
               rslt.valid <= 1'b1;
               rslt.last  <= 1'b1;
               rslt.index <= idx;
               rslt.limb  <= carry_q;
            end else begin
               rslt.valid <= 1'b0;
            end
         end
      end
   end

endmodule
